// File: rtl/life_gen_sequencer.sv
// Sequencer for a 4x4 Game-of-Life array: loads a seed, issues one-cycle step
// strobes on demand or at a fixed period, and classifies each new generation.
module life_gen_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      pattern_in,
    input  logic             load_req,
    input  logic             run,
    input  logic             single,
    input  logic [15:0]      alive_in,
    output logic [15:0]      val,
    output logic             write_enb,
    output logic             step,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             extinct,
    output logic             still,
    output logic             osc2,
    output logic [2:0]       state_dbg
);

    // Strobe protocol: write_enb and step are plain one-cycle pulses decoded
    // from the state register; there is no ready back-pressure, the array
    // must capture val on the write_enb cycle and advance on the rising step.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LSETTLE = 3'd2,
        S_WAIT    = 3'd3,
        S_STEP    = 3'd4,
        S_SSETTLE = 3'd5,
        S_SAMPLE  = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam int TICK_W = (TICK_DIV > 4) ? $clog2(TICK_DIV) : 2;
    // WAIT covers TICK_DIV-3 cycles so STEP+SSETTLE+SAMPLE+WAIT spans TICK_DIV.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 4);
    localparam logic [GEN_W-1:0]  GEN_MAX   = {GEN_W{1'b1}};

    state_t            state_q, state_d;
    logic [15:0]       val_q, val_d;
    logic [15:0]       prev1_q, prev1_d;
    logic [15:0]       prev2_q, prev2_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              pend_q, pend_d;
    logic              extinct_q, extinct_d;
    logic              still_q, still_d;
    logic              osc2_q, osc2_d;

    logic              is_extinct;
    logic              is_still;
    logic              is_osc2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            val_q     <= '0;
            prev1_q   <= '0;
            prev2_q   <= '0;
            gen_q     <= '0;
            tick_q    <= '0;
            pend_q    <= 1'b0;
            extinct_q <= 1'b0;
            still_q   <= 1'b0;
            osc2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            prev1_q   <= prev1_d;
            prev2_q   <= prev2_d;
            gen_q     <= gen_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
            extinct_q <= extinct_d;
            still_q   <= still_d;
            osc2_q    <= osc2_d;
        end
    end

    always_comb begin
        is_extinct = (alive_in == 16'h0000);
        is_still   = (alive_in == prev1_q);
        is_osc2    = (alive_in == prev2_q) && !is_still;
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        prev1_d   = prev1_q;
        prev2_d   = prev2_q;
        gen_d     = gen_q;
        tick_d    = '0;
        pend_d    = pend_q;
        extinct_d = extinct_q;
        still_d   = still_q;
        osc2_d    = osc2_q;

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    val_d   = pattern_in;
                end else if (single) begin
                    state_d = S_STEP;
                end else if (run) begin
                    state_d = S_WAIT;
                end
            end

            S_LOAD: begin
                gen_d     = '0;
                extinct_d = 1'b0;
                still_d   = 1'b0;
                osc2_d    = 1'b0;
                prev1_d   = '0;
                prev2_d   = '0;
                pend_d    = 1'b0;
                state_d   = S_LSETTLE;
            end

            S_LSETTLE: begin
                prev1_d = alive_in;
                state_d = run ? S_WAIT : S_IDLE;
            end

            S_WAIT: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    val_d   = pattern_in;
                end else if (single) begin
                    state_d = S_STEP;
                end else if (!run) begin
                    state_d = S_IDLE;
                end else if (tick_q == TICK_LAST) begin
                    state_d = S_STEP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_STEP: begin
                pend_d  = pend_q | load_req;
                state_d = S_SSETTLE;
            end

            S_SSETTLE: begin
                pend_d  = pend_q | load_req;
                state_d = S_SAMPLE;
            end

            S_SAMPLE: begin
                extinct_d = is_extinct;
                still_d   = is_still;
                osc2_d    = is_osc2;
                prev2_d   = prev1_q;
                prev1_d   = alive_in;
                if (gen_q != GEN_MAX) begin
                    gen_d = gen_q + GEN_W'(1);
                end
                // A load queued during the step wins over halting or continuing.
                if (pend_q || load_req) begin
                    state_d = S_LOAD;
                    val_d   = pattern_in;
                end else if (is_extinct || is_still) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    val_d   = pattern_in;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode the state register directly so reset removes them at once.
    always_comb begin
        write_enb = (state_q == S_LOAD);
        step      = (state_q == S_STEP);
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);
        val       = val_q;
        gen_count = gen_q;
        extinct   = extinct_q;
        still     = still_q;
        osc2      = osc2_q;
        state_dbg = state_q;
    end

endmodule
